// File: rtl/axi3_line_wr_arbiter_pkg.sv
// Shared AXI3 write-channel types and constants for the line-write arbiter.
// Contents: physical address type, burst encoding, size/response constants
// and the arbiter FSM state type.
package axi3_line_wr_arbiter_pkg;

    typedef logic [31:0] phys_t;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_t;

    localparam logic [2:0] AXI_SIZE_4B   = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

endpackage

// File: rtl/axi3_wr_if.sv
// AXI3 write address / write data / write response channels.
// master: drives AW, W and bready; slave: drives awready, wready and B.
interface axi3_wr_if #(
    parameter int BUS_WIDTH = 4
);
    logic [BUS_WIDTH-1:0] awid;
    logic [31:0]          awaddr;
    logic [3:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 awvalid;
    logic                 awready;

    logic [BUS_WIDTH-1:0] wid;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;

    logic [BUS_WIDTH-1:0] bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (request vector), last_grant (index granted last time),
//        grant (one-hot), grant_idx (binary index of grant; 0 when no request).
// The search starts one position after last_grant and wraps around.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            idx = (int'(last_grant) + off) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/axi3_line_wr_arbiter.sv
// Shares one AXI3 write channel among N_REQ cache-line writers. Each grant
// becomes one INCR burst of LINE_WIDTH/32 words; one transaction in flight.
// Ports: clk, rst (async, active-high); req_valid/req_addr/req_line per
//        requester; req_ready (one-hot accept), req_done (B received),
//        bus_err (B response not OKAY); axi (AXI3 write master).
module axi3_line_wr_arbiter
    import axi3_line_wr_arbiter_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int LINE_WIDTH = 256,
    parameter int AWID       = 2,
    parameter int BUS_WIDTH  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     req_valid,
    input  phys_t [N_REQ-1:0]                    req_addr,
    input  logic [N_REQ-1:0][LINE_WIDTH-1:0]     req_line,
    output logic [N_REQ-1:0]                     req_ready,
    output logic [N_REQ-1:0]                     req_done,
    output logic                                 bus_err,
    axi3_wr_if.master                            axi
);

    localparam int    BEATS     = LINE_WIDTH / 32;
    localparam int    BEAT_W    = $clog2(BEATS);
    localparam int    IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam phys_t LINE_MASK = phys_t'(LINE_WIDTH / 8 - 1);

    wr_state_t                 state_q, state_d;
    logic [IDX_W-1:0]          last_grant_q, last_grant_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    phys_t                     addr_q, addr_d;
    logic [BEATS-1:0][31:0]    line_q, line_d;

    logic [N_REQ-1:0]          grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      resp_fire;
    logic                      unused_bid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(N_REQ - 1);
            owner_q      <= '0;
            beat_q       <= '0;
            addr_q       <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            beat_q       <= beat_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        line_d       = line_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    owner_d = grant_idx;
                    addr_d  = req_addr[grant_idx] & ~LINE_MASK;
                    line_d  = req_line[grant_idx];
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (axi.awready) begin
                    beat_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (axi.wready) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (axi.bvalid) begin
                    last_grant_d = owner_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rst gates req_ready so the accept strobe drops with reset even while
    // requesters keep req_valid asserted.
    assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;

    assign resp_fire = (state_q == ST_RESP) && axi.bvalid;
    assign req_done  = resp_fire ? (N_REQ'(1) << owner_q) : '0;
    assign bus_err   = resp_fire && (axi.bresp != AXI_RESP_OKAY);

    assign axi.awid    = BUS_WIDTH'(AWID);
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 4'(BEATS - 1);
    assign axi.awsize  = AXI_SIZE_4B;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awvalid = (state_q == ST_ADDR);

    assign axi.wid     = BUS_WIDTH'(AWID);
    assign axi.wdata   = line_q[beat_q];
    assign axi.wstrb   = 4'hF;
    assign axi.wvalid  = (state_q == ST_DATA);
    assign axi.wlast   = (state_q == ST_DATA) && (beat_q == BEAT_W'(BEATS - 1));

    assign axi.bready  = (state_q == ST_RESP);

    assign unused_bid  = ^axi.bid;

endmodule

// File: tb/tb_axi3_line_wr_arbiter.sv
module tb_axi3_line_wr_arbiter;

    localparam int N_REQ  = 2;
    localparam int LINE_W = 256;
    localparam int BEATS  = LINE_W / 32;
    localparam int AWID   = 2;
    localparam int BUS_W  = 4;

    localparam int P_IDLE = 0;
    localparam int P_ADDR = 1;
    localparam int P_DATA = 2;
    localparam int P_RESP = 3;

    logic                          clk;
    logic                          rst;
    logic [N_REQ-1:0]              req_valid;
    logic [N_REQ-1:0][31:0]        req_addr;
    logic [N_REQ-1:0][LINE_W-1:0]  req_line;
    logic [N_REQ-1:0]              req_ready;
    logic [N_REQ-1:0]              req_done;
    logic                          bus_err;

    axi3_wr_if #(.BUS_WIDTH(BUS_W)) axi_bus ();

    axi3_line_wr_arbiter #(
        .N_REQ      (N_REQ),
        .LINE_WIDTH (LINE_W),
        .AWID       (AWID),
        .BUS_WIDTH  (BUS_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_line  (req_line),
        .req_ready (req_ready),
        .req_done  (req_done),
        .bus_err   (bus_err),
        .axi       (axi_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Round-robin rule: the pending requester closest after last_grant wins.
    function automatic int pick(input logic [N_REQ-1:0] v, input int last);
        int best = -1;
        int bestd = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) begin
                int d = (i - last - 1 + 2 * N_REQ) % N_REQ;
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    // ---------------- reference model + observation logs ----------------
    int                m_phase = P_IDLE;
    int                m_last  = N_REQ - 1;
    int                m_owner = 0;
    int                m_beat  = 0;
    logic [31:0]       m_addr;
    logic [LINE_W-1:0] m_line;

    int               cyc = 0;
    logic [N_REQ-1:0] last_ready = '0;
    int               glog[$];
    logic [N_REQ-1:0] dvec_log[$];
    logic             derr_log[$];
    logic [31:0]      wlog[$];
    int               dn_cnt = 0;
    int               rany_cnt = 0;
    int               gcyc = 0, dcyc = 0, awcyc = 0, w0cyc = 0, wlast_idx = -1;
    logic [31:0]      obs_awaddr;
    logic [3:0]       obs_awlen;
    logic [2:0]       obs_awsize;
    logic [1:0]       obs_awburst;
    logic [BUS_W-1:0] obs_awid;

    initial begin
        logic [N_REQ-1:0] er;
        logic [N_REQ-1:0] ed;
        int g;
        forever begin
            @(negedge clk);
            cyc++;
            last_ready = req_ready;
            if (rst) begin
                m_phase = P_IDLE;
                m_last  = N_REQ - 1;
                m_beat  = 0;
                continue;
            end

            // DUT observations for directed checks
            if (req_ready != '0) begin
                for (int i = 0; i < N_REQ; i++) if (req_ready[i]) glog.push_back(i);
                gcyc = cyc;
                wlog.delete();
                wlast_idx = -1;
                rany_cnt++;
            end
            if (axi_bus.awvalid && axi_bus.awready) begin
                awcyc = cyc;
                obs_awaddr = axi_bus.awaddr;
                obs_awlen = axi_bus.awlen;
                obs_awsize = axi_bus.awsize;
                obs_awburst = axi_bus.awburst;
                obs_awid = axi_bus.awid;
            end
            if (axi_bus.wvalid && axi_bus.wready) begin
                if (wlog.size() == 0) w0cyc = cyc;
                wlog.push_back(axi_bus.wdata);
                if (axi_bus.wlast) wlast_idx = wlog.size() - 1;
            end
            if (req_done != '0) begin
                dvec_log.push_back(req_done);
                derr_log.push_back(bus_err);
                dcyc = cyc;
                dn_cnt++;
            end

            // compare against the model's expectation for this cycle
            er = '0;
            if (m_phase == P_IDLE && req_valid != '0) er[pick(req_valid, m_last)] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("awvalid", axi_bus.awvalid, m_phase == P_ADDR);
            chk("wvalid", axi_bus.wvalid, m_phase == P_DATA);
            chk("bready", axi_bus.bready, m_phase == P_RESP);
            ed = '0;
            if (m_phase == P_RESP && axi_bus.bvalid) ed[m_owner] = 1'b1;
            chk("req_done", req_done, ed);
            chk("bus_err", bus_err, m_phase == P_RESP && axi_bus.bvalid && axi_bus.bresp != 2'b00);
            if (m_phase == P_ADDR) begin
                chk("awaddr", axi_bus.awaddr, m_addr);
                chk("awlen", axi_bus.awlen, BEATS - 1);
                chk("awsize", axi_bus.awsize, 3'b010);
                chk("awburst", axi_bus.awburst, 2'b01);
                chk("awid", axi_bus.awid, AWID);
            end
            if (m_phase == P_DATA) begin
                chk("wdata", axi_bus.wdata, m_line[m_beat*32 +: 32]);
                chk("wlast", axi_bus.wlast, m_beat == BEATS - 1);
                chk("wstrb", axi_bus.wstrb, 4'hF);
                chk("wid", axi_bus.wid, AWID);
            end else begin
                chk("wlast_idle", axi_bus.wlast, 1'b0);
            end

            // advance model by the handshakes of this cycle
            case (m_phase)
                P_IDLE: if (req_valid != '0) begin
                    g = pick(req_valid, m_last);
                    m_owner = g;
                    m_addr  = req_addr[g] - (req_addr[g] % (LINE_W / 8));
                    m_line  = req_line[g];
                    m_phase = P_ADDR;
                end
                P_ADDR: if (axi_bus.awready) begin
                    m_phase = P_DATA;
                    m_beat  = 0;
                end
                P_DATA: if (axi_bus.wready) begin
                    if (m_beat == BEATS - 1) m_phase = P_RESP;
                    else m_beat++;
                end
                default: if (axi_bus.bvalid) begin
                    m_last  = m_owner;
                    m_phase = P_IDLE;
                end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    bit               rand_mode = 0;
    bit               auto_en = 0;
    bit               gen_en = 0;
    bit               hold_valid = 0;
    bit               stall_en = 0;
    logic [1:0]       force_bresp = 2'b00;
    int               stall_cnt = 0;
    int               prev_beat = -1;
    logic [N_REQ-1:0] act = '0;

    task automatic drive_slave();
        logic [1:0] rs;
        axi_bus.awready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (m_phase != P_DATA || m_beat != prev_beat) stall_cnt = 0;
        prev_beat = (m_phase == P_DATA) ? m_beat : -1;
        if (stall_en && m_phase == P_DATA && (m_beat == 3 || m_beat == 6) && stall_cnt < 2) begin
            axi_bus.wready = 1'b0;
            stall_cnt++;
        end else begin
            axi_bus.wready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        axi_bus.bvalid = (m_phase == P_RESP) ? (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
        rs = 2'($urandom_range(0, 3));
        axi_bus.bresp = rand_mode ? ((rs == 2'b01) ? 2'b00 : rs) : force_bresp;
        axi_bus.bid = 4'(AWID);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N_REQ; i++) begin
            bit withdrawn = 0;
            if (last_ready[i]) act[i] = 1'b0;
            else if (act[i] && $urandom_range(0, 63) == 0) begin
                act[i] = 1'b0;
                withdrawn = 1;
            end
            if (!act[i] && !withdrawn && gen_en && $urandom_range(0, 3) == 0) begin
                act[i] = 1'b1;
                req_addr[i] = $urandom;
                for (int w = 0; w < BEATS; w++) req_line[i][w*32 +: 32] = $urandom;
            end
        end
        req_valid = act;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive_slave();
        if (auto_en) drive_reqs();
        else if (!hold_valid) req_valid = req_valid & ~last_ready;
    endtask

    task automatic run_until_done(input int n);
        int base = dn_cnt;
        int k = 0;
        while (dn_cnt < base + n && k < 400) begin
            step();
            k++;
        end
        if (dn_cnt < base + n) timeout("done_wait");
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic load_line(input int r, input logic [31:0] addr, input logic [31:0] base);
        req_addr[r] = addr;
        for (int w = 0; w < BEATS; w++) req_line[r][w*32 +: 32] = base + 32'(w);
    endtask

    initial begin
        int k;
        int base_dn;
        int base_r;
        rst = 1'b1;
        req_valid = 2'b11;
        req_addr = '0;
        req_line = '0;
        axi_bus.awready = 1'b0;
        axi_bus.wready = 1'b0;
        axi_bus.bvalid = 1'b0;
        axi_bus.bresp = 2'b00;
        axi_bus.bid = '0;
        #3;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_req_done", req_done, 2'b00);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_awvalid", axi_bus.awvalid, 1'b0);
        chk("rst_wvalid", axi_bus.wvalid, 1'b0);
        chk("rst_bready", axi_bus.bready, 1'b0);
        chk("rst_awaddr", axi_bus.awaddr, 32'h0);
        step();
        req_valid = 2'b00;
        step();
        rst = 1'b0;
        step();

        // single request, zero-wait slave
        load_line(0, 32'h1FC0_0024, 32'h0);
        req_valid = 2'b01;
        run_until_done(1);
        chk("single_done_lat", dcyc - gcyc, 10);
        chk("single_aw_lat", awcyc - gcyc, 1);
        chk("single_w0_lat", w0cyc - gcyc, 2);
        chk("single_awaddr", obs_awaddr, 32'h1FC0_0020);
        chk("single_awlen", obs_awlen, 4'd7);
        chk("single_awsize", obs_awsize, 3'd2);
        chk("single_awburst", obs_awburst, 2'd1);
        chk("single_awid", obs_awid, 4'd2);
        chk("single_nbeats", wlog.size(), 8);
        chk("single_wlast_idx", wlast_idx, 7);
        for (int w = 0; w < 8 && w < wlog.size(); w++) chk("single_wdata", wlog[w], 32'(w));
        chk("single_done_vec", dvec_log[$], 2'b01);

        // back-pressure on beats 3 and 6
        step();
        stall_en = 1;
        load_line(0, 32'h0000_1040, 32'hA0);
        req_valid = 2'b01;
        run_until_done(1);
        stall_en = 0;
        chk("bp_done_lat", dcyc - gcyc, 14);
        chk("bp_nbeats", wlog.size(), 8);
        for (int w = 0; w < 8 && w < wlog.size(); w++) chk("bp_wdata", wlog[w], 32'hA0 + 32'(w));

        // error response for requester 1, then a normal one
        step();
        force_bresp = 2'b10;
        load_line(1, 32'h2000_0000, 32'h100);
        req_valid = 2'b10;
        run_until_done(1);
        chk("err_done_vec", dvec_log[$], 2'b10);
        chk("err_bus_err", derr_log[$], 1'b1);
        force_bresp = 2'b00;
        load_line(0, 32'h3000_0000, 32'h200);
        req_valid = 2'b01;
        run_until_done(1);
        chk("after_err_done_vec", dvec_log[$], 2'b01);
        chk("after_err_bus_err", derr_log[$], 1'b0);
        chk("after_err_lat", dcyc - gcyc, 10);

        // withdrawn request from requester 1 while requester 0 is in flight
        step();
        load_line(0, 32'h4000_0000, 32'h300);
        req_valid = 2'b01;
        k = 0;
        while (m_phase != P_DATA && k < 50) begin step(); k++; end
        if (m_phase != P_DATA) timeout("withdraw_wait");
        base_r = rany_cnt;
        load_line(1, 32'h5000_0000, 32'h400);
        req_valid[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        run_until_done(1);
        repeat (5) step();
        chk("withdraw_no_ready", rany_cnt - base_r, 0);
        chk("withdraw_owner", glog[$], 0);

        // contention after reset: strict alternation
        do_reset();
        glog.delete();
        hold_valid = 1;
        load_line(0, 32'h6000_0000, 32'h500);
        load_line(1, 32'h7000_0040, 32'h600);
        req_valid = 2'b11;
        run_until_done(4);
        req_valid = 2'b00;
        hold_valid = 0;
        chk("cont_ngrants", glog.size(), 4);
        if (glog.size() >= 4) begin
            chk("cont_g0", glog[0], 0);
            chk("cont_g1", glog[1], 1);
            chk("cont_g2", glog[2], 0);
            chk("cont_g3", glog[3], 1);
        end

        // reset in the middle of the data phase
        step();
        load_line(0, 32'h8000_0000, 32'h700);
        req_valid = 2'b01;
        k = 0;
        while (!(m_phase == P_DATA && m_beat == 4) && k < 50) begin step(); k++; end
        if (!(m_phase == P_DATA && m_beat == 4)) timeout("midrst_wait");
        load_line(0, 32'h8000_0000, 32'h700);
        load_line(1, 32'h9000_0000, 32'h800);
        req_valid = 2'b11;
        base_dn = dn_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, 2'b00);
        chk("midrst_req_done", req_done, 2'b00);
        chk("midrst_bus_err", bus_err, 1'b0);
        chk("midrst_awvalid", axi_bus.awvalid, 1'b0);
        chk("midrst_wvalid", axi_bus.wvalid, 1'b0);
        chk("midrst_wlast", axi_bus.wlast, 1'b0);
        chk("midrst_bready", axi_bus.bready, 1'b0);
        hold_valid = 1;
        step();
        step();
        glog.delete();
        rst = 1'b0;
        k = 0;
        while (glog.size() == 0 && k < 20) begin step(); k++; end
        if (glog.size() == 0) timeout("midrst_grant");
        else chk("midrst_first_grant", glog[0], 0);
        chk("midrst_no_done", dn_cnt - base_dn, 0);
        hold_valid = 0;
        req_valid = 2'b10;
        run_until_done(2);

        // randomized traffic with random slave stalls and responses
        rand_mode = 1;
        act = '0;
        auto_en = 1;
        gen_en = 1;
        repeat (3000) step();
        gen_en = 0;
        k = 0;
        while ((act != '0 || m_phase != P_IDLE) && k < 3000) begin step(); k++; end
        if (act != '0 || m_phase != P_IDLE) timeout("drain");
        auto_en = 0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
